// File: rtl/sequence_difference_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_difference_decoder_if
//  Description : Valid/ready bundle for the running-sum decoder: the sum
//                input channel and the decoded-sample output channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sequence_difference_decoder_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     sum_in;
    logic                 restart;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     data_out;
    logic                 wrap;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] count;

    // Upstream source / downstream sink side of the bundle
    modport master (
        output sum_in, restart, in_valid, out_ready,
        input  in_ready, data_out, wrap, out_valid, count
    );

    // Decoder side of the bundle
    modport slave (
        input  sum_in, restart, in_valid, out_ready,
        output in_ready, data_out, wrap, out_valid, count
    );
endinterface
`default_nettype wire

// File: rtl/sequence_difference_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : sequence_difference_decoder
//  Description : Recovers original samples from a stream of accumulated sums
//                by subtracting the previously accepted sum. Flags borrow
//                (accumulator wrap) and keeps a saturating sample count.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequence_difference_decoder #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     reset,
    sequence_difference_decoder_if.slave  bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     r_data;
    logic                 r_wrap;
    logic [CNT_WIDTH-1:0] r_count;

    logic                 w_accept;
    logic [WIDTH-1:0]     w_base;
    logic [WIDTH:0]       w_diff;

    // The output slot can take a new sum when empty or when it is being drained
    assign bus.in_ready  = (r_state == EMPTY) || bus.out_ready;
    assign w_accept      = bus.in_valid && bus.in_ready;

    // A restart means the upstream accumulator was cleared, so decode against zero
    assign w_base        = bus.restart ? '0 : r_prev;
    // Extra MSB captures the borrow, which is exactly the wrap indication
    assign w_diff        = {1'b0, bus.sum_in} - {1'b0, w_base};

    assign bus.out_valid = (r_state == FULL);
    assign bus.data_out  = r_data;
    assign bus.wrap      = r_wrap;
    assign bus.count     = r_count;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: fill on accept, drain only when consumed without a refill
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !w_accept) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    // Datapath: decode, remember the sum and update the saturating count on accept
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev  <= '0;
            r_data  <= '0;
            r_wrap  <= 1'b0;
            r_count <= '0;
        end else if (w_accept) begin
            r_prev <= bus.sum_in;
            r_data <= w_diff[WIDTH-1:0];
            r_wrap <= w_diff[WIDTH];
            if (bus.restart) begin
                r_count <= CNT_WIDTH'(1);
            end else if (r_count != {CNT_WIDTH{1'b1}}) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sequence_difference_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequence_difference_decoder
//  Description : Self-checking bench for sequence_difference_decoder. Two
//                instances (8-bit and 2-bit counters) share one stimulus
//                stream and are compared against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequence_difference_decoder;

    logic clk;
    logic reset;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    bit       m_valid = 1'b0;
    int       m_prev  = 0;
    int       m_data  = 0;
    bit       m_wrap  = 1'b0;
    int       m_count = 0;

    sequence_difference_decoder_if #(.WIDTH(8), .CNT_WIDTH(8)) bus_a ();
    sequence_difference_decoder_if #(.WIDTH(8), .CNT_WIDTH(2)) bus_b ();

    sequence_difference_decoder #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    sequence_difference_decoder #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready before the edge,
    // advance the model at the edge, check registered outputs after it.
    task automatic step(input bit rst_n, input bit v, input bit rs,
                        input logic [7:0] s, input bit ordy);
        bit exp_ready;
        bit acc;
        int base;
        int diff;
        reset          = rst_n;
        bus_a.in_valid = v;  bus_b.in_valid  = v;
        bus_a.restart  = rs; bus_b.restart   = rs;
        bus_a.sum_in   = s;  bus_b.sum_in    = s;
        bus_a.out_ready = ordy; bus_b.out_ready = ordy;
        #1;
        exp_ready = !m_valid || ordy;
        chk("in_ready",     {31'd0, bus_a.in_ready}, {31'd0, exp_ready});
        chk("in_ready_sat", {31'd0, bus_b.in_ready}, {31'd0, exp_ready});
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 1'b0; m_prev = 0; m_data = 0; m_wrap = 1'b0; m_count = 0;
        end else begin
            acc = v && exp_ready;
            if (m_valid && ordy && !acc) m_valid = 1'b0;
            if (acc) begin
                base    = rs ? 0 : m_prev;
                diff    = int'(s) - base;
                m_wrap  = (diff < 0);
                m_data  = (diff + 256) % 256;
                m_prev  = int'(s);
                m_count = rs ? 1 : m_count + 1;
                m_valid = 1'b1;
            end
        end
        #1;
        chk("out_valid",     {31'd0, bus_a.out_valid}, {31'd0, m_valid});
        chk("data_out",      {24'd0, bus_a.data_out},  m_data);
        chk("wrap",          {31'd0, bus_a.wrap},      {31'd0, m_wrap});
        chk("count",         {24'd0, bus_a.count},     (m_count > 255) ? 255 : m_count);
        chk("out_valid_sat", {31'd0, bus_b.out_valid}, {31'd0, m_valid});
        chk("data_out_sat",  {24'd0, bus_b.data_out},  m_data);
        chk("wrap_sat",      {31'd0, bus_b.wrap},      {31'd0, m_wrap});
        chk("count_sat",     {30'd0, bus_b.count},     (m_count > 3) ? 3 : m_count);
        @(negedge clk);
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        reset = 1'b0;
        bus_a.in_valid = 1'b0; bus_b.in_valid = 1'b0;
        bus_a.restart = 1'b0;  bus_b.restart = 1'b0;
        bus_a.sum_in = 8'h00;  bus_b.sum_in = 8'h00;
        bus_a.out_ready = 1'b1; bus_b.out_ready = 1'b1;
        // First edge brings registers out of X; no checks until it has passed
        @(posedge clk);
        @(negedge clk);

        // Reset held with a valid sum presented: it must be discarded
        step(1'b0, 1'b1, 1'b0, 8'h55, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h55, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h07, 1'b1);     // -> 0x07
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Accumulator pairing: 1,1,3,0x33; count ends at 4
        step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h02, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h05, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h38, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Wrap-around: 0xF0 then 0x10 -> 0x20 with wrap, then 0x10 -> 0x00
        step(1'b1, 1'b1, 1'b0, 8'hF0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h10, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'h10, 1'b1);

        // Restart from prev=0x38 with sum 0xFF
        step(1'b1, 1'b1, 1'b0, 8'h38, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Backpressure: 0x03 held for three stalled cycles, then 0x0A -> 0x07
        step(1'b1, 1'b1, 1'b1, 8'h03, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 8'h0A, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h0A, 1'b1);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b1);

        // Count saturation on the 2-bit instance: five accepts after restart
        step(1'b1, 1'b1, 1'b1, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(2 + i), 1'b1);

        // Reset while FULL, then decode against base 0
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h0C, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h0C, 1'b0);
        step(1'b1, 1'b1, 1'b0, 8'h09, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) == 0),
                 8'($urandom),
                 ($urandom_range(0, 9) < 7));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
